cpu_control: RTL

- Multi-cycle sequencer for the CPU datapath built around the ALU.
- Drives instruction fetch, decode, execute, memory access and writeback as a single FSM.
- Uses the ALU comparison flags to resolve branches.
- Produces all datapath enables and mux selects: PC, instruction register, register file, memory port and CSR file. Sits beside the ALU/register file inside the cpu top.

---
 rtl/cpu_control_pkg.sv | 96 +++++++++
 rtl/cpu_control_if.sv | 32 +++
 rtl/cpu_control_branch_resolve.sv | 25 ++
 rtl/cpu_control.sv | 131 +++++++++++++
 4 files changed

// File: rtl/cpu_control_pkg.sv
// Shared types, encodings and decode helpers for the cpu_control sequencer.
// Macro CPU_ZICSR_EN makes the CSR forms of the SYSTEM opcode legal.
package cpu_control_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned STRB_W  = 4;
  localparam int unsigned RDSEL_W = 2;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WRITEBACK,
    ST_TRAP
  } state_e;

  localparam logic [RDSEL_W-1:0] RD_SEL_ALU  = 2'd0;
  localparam logic [RDSEL_W-1:0] RD_SEL_LOAD = 2'd1;
  localparam logic [RDSEL_W-1:0] RD_SEL_PC4  = 2'd2;
  localparam logic [RDSEL_W-1:0] RD_SEL_CSR  = 2'd3;

  localparam logic PC_SEL_PC4 = 1'b0;
  localparam logic PC_SEL_ALU = 1'b1;

  localparam logic [STRB_W-1:0] WSTRB_NONE = 4'b0000;
  localparam logic [STRB_W-1:0] WSTRB_BYTE = 4'b0001;
  localparam logic [STRB_W-1:0] WSTRB_HALF = 4'b0011;
  localparam logic [STRB_W-1:0] WSTRB_WORD = 4'b1111;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic eq;
    logic neq;
    logic lt;
    logic ltu;
    logic ge;
    logic geu;
  } cmp_flags_t;

  // Opcode/funct3 legality; branch funct3 validity comes from the branch resolver.
  function automatic logic decode_legal(input logic [6:0] opcode, input logic [2:0] funct3,
                                        input logic br_valid);
    logic legal;
    legal = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_OP_IMM, OPC_OP, OPC_MISC_MEM: legal = 1'b1;
      OPC_BRANCH: legal = br_valid;
      OPC_LOAD:   legal = (funct3 != 3'b011) && (funct3 < 3'b110);
      OPC_STORE:  legal = (funct3 < 3'b011);
`ifdef CPU_ZICSR_EN
      OPC_SYSTEM: legal = (funct3 != 3'b000) && (funct3 != 3'b100);
`endif
      default:    legal = 1'b0;
    endcase
    return legal;
  endfunction

  // size is funct3[1:0]: 00 byte, 01 half, 10 word.
  function automatic logic mem_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (size)
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~addr_lo[0];
      2'b10:   ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [STRB_W-1:0] store_wstrb(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [STRB_W-1:0] strb;
    strb = WSTRB_WORD;
    case (size)
      2'b00:   strb = WSTRB_BYTE << addr_lo;
      2'b01:   strb = WSTRB_HALF << addr_lo;
      default: strb = WSTRB_WORD;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/cpu_control_if.sv
// Control bundle between the cpu_control sequencer (master) and the datapath (slave).
interface cpu_control_if;

  logic [cpu_control_pkg::XLEN-1:0]    instruction;
  logic                                eq, neq, lt, ltu, ge, geu;
  logic [1:0]                          addr_lo;
  logic                                mem_ready;
  logic                                mem_valid;
  logic                                mem_we;
  logic [cpu_control_pkg::STRB_W-1:0]  mem_wstrb;
  logic                                mem_addr_sel;
  logic                                ir_we;
  logic                                pc_we;
  logic                                pc_sel;
  logic                                reg_we;
  logic [cpu_control_pkg::RDSEL_W-1:0] rd_sel;
  logic                                csr_we;
  logic                                trap;

  modport master (
    input  instruction, eq, neq, lt, ltu, ge, geu, addr_lo, mem_ready,
    output mem_valid, mem_we, mem_wstrb, mem_addr_sel, ir_we, pc_we, pc_sel,
           reg_we, rd_sel, csr_we, trap
  );

  modport slave (
    output instruction, eq, neq, lt, ltu, ge, geu, addr_lo, mem_ready,
    input  mem_valid, mem_we, mem_wstrb, mem_addr_sel, ir_we, pc_we, pc_sel,
           reg_we, rd_sel, csr_we, trap
  );

endinterface

// File: rtl/cpu_control_branch_resolve.sv
// Branch condition resolver: picks the ALU flag named by funct3; 010/011 are not branches.
module cpu_control_branch_resolve
  import cpu_control_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  cmp_flags_t i_flags,
  output logic       o_taken_c,
  output logic       o_valid_c
);

  always_comb begin
    o_taken_c = 1'b0;
    o_valid_c = 1'b1;
    case (i_funct3)
      3'b000:  o_taken_c = i_flags.eq;
      3'b001:  o_taken_c = i_flags.neq;
      3'b100:  o_taken_c = i_flags.lt;
      3'b101:  o_taken_c = i_flags.ge;
      3'b110:  o_taken_c = i_flags.ltu;
      3'b111:  o_taken_c = i_flags.geu;
      default: o_valid_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle sequencer: one FSM stepping fetch/decode/execute/mem/writeback for the datapath.
// Define CPU_ZICSR_EN to accept CSR instructions (writeback of CSR read data plus csr_we).
module cpu_control
  import cpu_control_pkg::*;
#(
  parameter bit RESET_STATE_FETCH = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  cpu_control_if.master bus
);

  state_e     r_state;
  state_e     w_next_state;
  logic       r_rst_wait;
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [4:0] w_rd;
  logic       w_is_store;
  logic       w_is_mem;
  cmp_flags_t w_flags;
  logic       w_br_taken_c;
  logic       w_br_valid_c;
  logic       w_unused;

  assign w_opcode   = bus.instruction[6:0];
  assign w_funct3   = bus.instruction[14:12];
  assign w_rd       = bus.instruction[11:7];
  assign w_is_store = (w_opcode == OPC_STORE);
  assign w_is_mem   = (w_opcode == OPC_LOAD) || w_is_store;
  assign w_flags    = {bus.eq, bus.neq, bus.lt, bus.ltu, bus.ge, bus.geu};
  assign w_unused   = ^bus.instruction[31:15];

  cpu_control_branch_resolve u_branch (
    .i_funct3  (w_funct3),
    .i_flags   (w_flags),
    .o_taken_c (w_br_taken_c),
    .o_valid_c (w_br_valid_c)
  );

  // r_rst_wait marks the first post-reset cycle for the optional extra idle cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RESET;
      r_rst_wait <= 1'b1;
    end else begin
      r_state    <= w_next_state;
      if (r_state == ST_RESET) r_rst_wait <= 1'b0;
    end
  end

  // Strobes decode from state; all are held low while reset is asserted.
  always_comb begin
    w_next_state     = r_state;
    bus.mem_valid    = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_wstrb    = WSTRB_NONE;
    bus.mem_addr_sel = 1'b0;
    bus.ir_we        = 1'b0;
    bus.pc_we        = 1'b0;
    bus.pc_sel       = PC_SEL_PC4;
    bus.reg_we       = 1'b0;
    bus.rd_sel       = RD_SEL_ALU;
    bus.csr_we       = 1'b0;
    bus.trap         = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_RESET: begin
          if (RESET_STATE_FETCH || !r_rst_wait) w_next_state = ST_FETCH;
        end
        ST_FETCH: begin
          bus.mem_valid = 1'b1;
          if (bus.mem_ready) begin
            bus.ir_we    = 1'b1;
            w_next_state = ST_DECODE;
          end
        end
        ST_DECODE: begin
          w_next_state = decode_legal(w_opcode, w_funct3, w_br_valid_c) ? ST_EXECUTE : ST_TRAP;
        end
        ST_EXECUTE: begin
          if (w_opcode == OPC_BRANCH) begin
            bus.pc_we    = 1'b1;
            bus.pc_sel   = w_br_taken_c ? PC_SEL_ALU : PC_SEL_PC4;
            w_next_state = ST_FETCH;
          end else if (w_is_mem) begin
            w_next_state = mem_aligned(w_funct3[1:0], bus.addr_lo) ? ST_MEM : ST_TRAP;
          end else begin
            w_next_state = ST_WRITEBACK;
          end
        end
        ST_MEM: begin
          bus.mem_valid    = 1'b1;
          bus.mem_addr_sel = 1'b1;
          if (w_is_store) begin
            bus.mem_we    = 1'b1;
            bus.mem_wstrb = store_wstrb(w_funct3[1:0], bus.addr_lo);
          end
          if (bus.mem_ready) begin
            bus.pc_we    = w_is_store;
            w_next_state = w_is_store ? ST_FETCH : ST_WRITEBACK;
          end
        end
        ST_WRITEBACK: begin
          bus.pc_we    = 1'b1;
          bus.reg_we   = (w_rd != 5'd0);
          w_next_state = ST_FETCH;
          case (w_opcode)
            OPC_LOAD: bus.rd_sel = RD_SEL_LOAD;
            OPC_JAL, OPC_JALR: begin
              bus.rd_sel = RD_SEL_PC4;
              bus.pc_sel = PC_SEL_ALU;
            end
            OPC_MISC_MEM: bus.reg_we = 1'b0;
`ifdef CPU_ZICSR_EN
            // Set/clear forms with a zero rs1/uimm only read the CSR.
            OPC_SYSTEM: begin
              bus.rd_sel = RD_SEL_CSR;
              bus.csr_we = !(w_funct3[1] && (bus.instruction[19:15] == 5'd0));
            end
`endif
            default: ;
          endcase
        end
        ST_TRAP: bus.trap = 1'b1;
        default: w_next_state = ST_RESET;
      endcase
    end
  end

endmodule
